// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits in STAGES slices with valid/ready flow control.
// Optional build macro CLA_PIPE_FLAGS_EN enables the registered ovf_o/zero_o flags.
module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int CW = WIDTH / STAGES;
  localparam int NG = CW / 4;

  // One slice: 4-bit lookahead groups, group carries resolved by lookahead across the slice.
  function automatic logic [CW:0] slice_add(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                            input logic ci);
    logic [CW-1:0] p, g, c;
    logic [NG-1:0] gg, pg;
    logic [NG:0]   cg;
    logic          t;
    p = a ^ b;
    g = a & b;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      pg[j] = &p[4*j +: 4];
    end
    for (int j = 0; j <= NG; j++) begin
      cg[j] = ci;
      for (int i = 0; i < j; i++) cg[j] = cg[j] & pg[i];
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t = t & pg[m];
        cg[j] = cg[j] | t;
      end
    end
    for (int j = 0; j < NG; j++) begin
      c[4*j]   = cg[j];
      c[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
    end
    return {cg[NG], p ^ c};
  endfunction

  logic [WIDTH-1:0] bx;
  logic             c0;

  assign bx = sub_i ? ~b_i : b_i;
  assign c0 = sub_i ? ~cin_i : cin_i;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = (k + 1) * CW;
    logic                  vld, adv, c, src_vld, src_c;
    logic [WIDTH-k*CW-1:0] src_a, src_b;
    logic [LO-1:0]         sum, sum_n;
    logic [CW:0]           res;

    if (k == 0) begin : g_src
      assign src_vld = in_valid;
      assign src_a   = a_i;
      assign src_b   = bx;
      assign src_c   = c0;
      assign sum_n   = res[CW-1:0];
    end else begin : g_src
      assign src_vld = stg[k-1].vld;
      assign src_a   = stg[k-1].g_op.a_up;
      assign src_b   = stg[k-1].g_op.b_up;
      assign src_c   = stg[k-1].c;
      assign sum_n   = {res[CW-1:0], stg[k-1].sum};
    end

    if (k == STAGES - 1) begin : g_adv
      assign adv = ~vld | out_ready;
    end else begin : g_adv
      assign adv = ~vld | stg[k+1].adv;
    end

    assign res = slice_add(src_a[CW-1:0], src_b[CW-1:0], src_c);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld <= 1'b0;
        c   <= 1'b0;
        sum <= '0;
      end else if (adv) begin
        vld <= src_vld;
        if (src_vld) begin
          c   <= res[CW];
          sum <= sum_n;
        end
      end
    end

    // Operand bits not yet consumed travel with the op to the next slice.
    if (k < STAGES - 1) begin : g_op
      logic [WIDTH-LO-1:0] a_up, b_up;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_up <= '0;
          b_up <= '0;
        end else if (adv && src_vld) begin
          a_up <= src_a[WIDTH-k*CW-1:CW];
          b_up <= src_b[WIDTH-k*CW-1:CW];
        end
      end
    end
  end

  assign in_ready  = stg[0].adv;
  assign out_valid = stg[STAGES-1].vld;
  assign sum_o     = stg[STAGES-1].sum;
  assign cout_o    = stg[STAGES-1].c;

`ifdef CLA_PIPE_FLAGS_EN
  logic cmsb;
  // Carry into the MSB recovered from its sum bit: s ^ a ^ b'.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmsb <= 1'b0;
    end else if (stg[STAGES-1].adv && stg[STAGES-1].src_vld) begin
      cmsb <= stg[STAGES-1].res[CW-1] ^ stg[STAGES-1].src_a[CW-1] ^ stg[STAGES-1].src_b[CW-1];
    end
  end
  assign ovf_o  = cmsb ^ cout_o;
  assign zero_o = out_valid & ~|sum_o;
`else
  assign ovf_o  = 1'b0;
  assign zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed-vector and flow-control bench for cla_pipe_adder (WIDTH=16, STAGES=2).
module tb_cla_pipe_adder;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] sum;
    logic        cout, ovf, zero;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout, ovf, zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] a_i = '0, b_i = '0;
  logic        cin_i = 1'b0, sub_i = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] sum_o;
  logic        cout_o, ovf_o, zero_o;

  int          checks = 0, failures = 0;
  int          cyc = 0, n_out = 0, first_out = -1, last_out = -1;
  logic        hold_pend = 1'b0;
  logic [18:0] snap;
  exp_t        q[$];
  exp_t        none;

  cla_pipe_adder #(.WIDTH(16), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .sub_i(sub_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_o(sum_o), .cout_o(cout_o), .ovf_o(ovf_o), .zero_o(zero_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t gate(input exp_t e);
    exp_t r = e;
`ifndef CLA_PIPE_FLAGS_EN
    r.ovf  = 1'b0;
    r.zero = 1'b0;
`endif
    return r;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                                 input logic su);
    exp_t        e;
    logic [15:0] bb;
    logic [16:0] f;
    bb     = su ? ~b : b;
    f      = {1'b0, a} + {1'b0, bb} + {16'd0, su ? ~ci : ci};
    e.sum  = f[15:0];
    e.cout = f[16];
    e.ovf  = (a[15] == bb[15]) && (f[15] != a[15]);
    e.zero = (f[15:0] == 16'd0);
    return gate(e);
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, handshakes happen at the next posedge.
  task automatic cycle(input logic iv, input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic su, input logic ordy, input exp_t e, output logic took);
    exp_t x;
    @(negedge clk);
    in_valid = iv; a_i = a; b_i = b; cin_i = ci; sub_i = su; out_ready = ordy;
    #1;
    cyc++;
    if (hold_pend) chk("hold_stable", {13'd0, sum_o, cout_o, ovf_o, zero_o}, {13'd0, snap});
    if (out_valid && out_ready) begin
      n_out++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      if (q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        x = q.pop_front();
        chk($sformatf("sum#%0d", n_out), {16'd0, sum_o}, {16'd0, x.sum});
        chk($sformatf("cout#%0d", n_out), {31'd0, cout_o}, {31'd0, x.cout});
        chk($sformatf("ovf#%0d", n_out), {31'd0, ovf_o}, {31'd0, x.ovf});
        chk($sformatf("zero#%0d", n_out), {31'd0, zero_o}, {31'd0, x.zero});
      end
    end
    hold_pend = out_valid && !out_ready;
    snap = {sum_o, cout_o, ovf_o, zero_o};
    took = in_valid && in_ready;
    if (took) q.push_back(e);
  endtask

  task automatic idle(input logic ordy);
    logic t;
    cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, ordy, none, t);
  endtask

  initial begin
    vec_t        tv[10];
    exp_t        e;
    logic        took;
    logic [15:0] pa[4], pb[4];
    int          idx, n0, acc0;

    none = '{default: '0};
    tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tv[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tv[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tv[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tv[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    tv[5] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    tv[6] = '{16'h5555, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tv[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tv[8] = '{16'h00FF, 16'hFF00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tv[9] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

    // reset state
    @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_sum", {16'd0, sum_o}, 32'd0);
    chk("rst_cout", {31'd0, cout_o}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_o}, 32'd0);
    chk("rst_zero", {31'd0, zero_o}, 32'd0);
    rst = 1'b0;

    // directed table, one op at a time, latency checked per op
    for (int i = 0; i < 10; i++) begin
      e = gate('{tv[i].sum, tv[i].cout, tv[i].ovf, tv[i].zero});
      cycle(1'b1, tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, 1'b1, e, took);
      chk($sformatf("vec%0d_accept", i), {31'd0, took}, 32'd1);
      idle(1'b1);
      chk($sformatf("vec%0d_early", i), {31'd0, out_valid}, 32'd0);
      idle(1'b1);
      chk($sformatf("vec%0d_lat", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_done", i), q.size(), 32'd0);
    end

    // back-to-back stream
    first_out = -1;
    n0 = n_out;
    acc0 = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      pa[0] = 16'($urandom); pb[0] = 16'($urandom);
      e = model(pa[0], pb[0], i[0], i[1]);
      cycle(1'b1, pa[0], pb[0], i[0], i[1], 1'b1, e, took);
      chk($sformatf("stream_accept%0d", i), {31'd0, took}, 32'd1);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) idle(1'b1);
    chk("stream_count", n_out - n0, 32'd8);
    chk("stream_first", first_out, acc0 + 2);
    chk("stream_consec", last_out - first_out, 32'd7);

    // back-pressure: only two ops fit
    for (int i = 0; i < 4; i++) begin
      pa[i] = 16'($urandom); pb[i] = 16'($urandom);
    end
    idx = 0;
    n0 = n_out;
    for (int i = 0; i < 6; i++) begin
      e = model(pa[idx & 3], pb[idx & 3], 1'b0, idx[0]);
      cycle(idx < 4, pa[idx & 3], pb[idx & 3], 1'b0, idx[0], 1'b0, e, took);
      if (took) idx++;
    end
    chk("bp_taken", idx, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 20 && (q.size() > 0 || idx < 4); i++) begin
      e = model(pa[idx & 3], pb[idx & 3], 1'b0, idx[0]);
      cycle(idx < 4, pa[idx & 3], pb[idx & 3], 1'b0, idx[0], 1'b1, e, took);
      if (took) idx++;
    end
    idle(1'b1);
    chk("bp_all_taken", idx, 32'd4);
    chk("bp_drained", n_out - n0, 32'd4);

    // reset with two ops in flight
    for (int i = 0; i < 2; i++) begin
      e = model(pa[i], pb[i], 1'b1, 1'b0);
      cycle(1'b1, pa[i], pb[i], 1'b1, 1'b0, 1'b0, e, took);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_outs", {13'd0, sum_o, cout_o, ovf_o, zero_o}, 32'd0);
    q.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("post_rst_no_stale", n_out - n0, 32'd0);
    e = gate('{16'h0007, 1'b0, 1'b0, 1'b0});
    cycle(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1, e, took);
    chk("post_rst_accept", {31'd0, took}, 32'd1);
    idle(1'b1);
    idle(1'b1);
    chk("post_rst_done", n_out - n0, 32'd1);
    chk("post_rst_queue", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
